// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream offer/accept
// on the in_* side, downstream offer/accept on the out_* side.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // Environment side: offers upstream payload, accepts downstream payload.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side: accepts upstream payload, offers downstream payload.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer. in_ready depends
// only on local state and flush, so there is no combinational path from
// out_ready back to in_ready. Also keeps a saturating count of cycles in
// which valid output was back-pressured.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             fire_in;
  logic             fire_out;

  // Handshake outputs come straight from registered state; main_reg is
  // forced to the bubble value whenever the stage empties.
  assign bus.in_ready  = (state_reg != ST_FULL) && !flush;
  assign bus.out_valid = (state_reg != ST_EMPTY);
  assign bus.out_data  = main_reg;
  assign stall_cnt     = stall_cnt_reg;

  assign fire_in  = bus.in_valid  && bus.in_ready  && rdy;
  assign fire_out = bus.out_valid && bus.out_ready && rdy;

  // Number of held entries derived from the state.
  always_comb begin
    occupancy = 2'd0;
    case (state_reg)
      ST_HALF: occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and datapath: flush wins, then the EMPTY/HALF/FULL transfers.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (rdy) begin
      if (flush) begin
        state_next = ST_EMPTY;
        main_next  = NOP_VALUE;
        skid_next  = NOP_VALUE;
      end else begin
        case (state_reg)
          ST_EMPTY: begin
            if (fire_in) begin
              state_next = ST_HALF;
              main_next  = bus.in_data;
            end
          end
          ST_HALF: begin
            if (fire_in && fire_out) begin
              main_next = bus.in_data;
            end else if (fire_in) begin
              state_next = ST_FULL;
              skid_next  = bus.in_data;
            end else if (fire_out) begin
              state_next = ST_EMPTY;
              main_next  = NOP_VALUE;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only a drain can happen.
            if (fire_out) begin
              state_next = ST_HALF;
              main_next  = skid_reg;
            end
          end
          default: begin
            state_next = ST_EMPTY;
            main_next  = NOP_VALUE;
            skid_next  = NOP_VALUE;
          end
        endcase
      end
    end
  end

  // Back-pressure counter: counts stalled valid cycles, sticks at all-ones.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (rdy && bus.out_valid && !bus.out_ready && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + CNT_ONE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= NOP_VALUE;
      skid_reg      <= NOP_VALUE;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default-width instance and a CNT_W=2
// instance share one stimulus stream. A queue-based model of the stage
// is compared against both every cycle; directed steps add literal checks.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [31:0] NOP = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [1:0]  stall_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: held payloads in acceptance order plus two counters.
  logic [31:0] mq[$];
  int          m_cnt = 0;
  int          m_sat = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(W)) bus_a ();
  pipe_stage_reg_if #(.WIDTH(W)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.out_ready = out_ready;

  pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(16)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .bus       (bus_a),
    .occupancy (occ_a),
    .stall_cnt (stall_a)
  );

  pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .bus       (bus_b),
    .occupancy (occ_b),
    .stall_cnt (stall_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a queue of at most two entries, popped on delivery,
  // pushed on acceptance, emptied by flush or reset.
  logic model_out, model_in;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
      m_sat = 0;
    end else if (rdy) begin
      model_out = (mq.size() > 0) && out_ready;
      model_in  = in_valid && (mq.size() < 2) && !flush;
      if ((mq.size() > 0) && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
      if (model_out) begin
        $display("xfer out data=%h t=%0t", mq[0], $time);
        void'(mq.pop_front());
      end
      if (flush) begin
        if (mq.size() > 0) $display("flush drops %0d entr(ies) t=%0t", mq.size(), $time);
        mq.delete();
      end else if (model_in) begin
        $display("xfer in  data=%h t=%0t", in_data, $time);
        mq.push_back(in_data);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  logic [31:0] exp_data;
  always @(negedge clk) begin
    exp_data = (mq.size() > 0) ? mq[0] : NOP;
    cmp("a.out_valid", {31'b0, bus_a.out_valid}, {31'b0, mq.size() > 0});
    cmp("a.out_data",  bus_a.out_data, exp_data);
    cmp("a.occupancy", {30'b0, occ_a}, mq.size());
    cmp("a.in_ready",  {31'b0, bus_a.in_ready}, {31'b0, (mq.size() < 2) && !flush});
    cmp("a.stall_cnt", {16'b0, stall_a}, m_cnt);
    cmp("b.out_valid", {31'b0, bus_b.out_valid}, {31'b0, mq.size() > 0});
    cmp("b.out_data",  bus_b.out_data, exp_data);
    cmp("b.occupancy", {30'b0, occ_b}, mq.size());
    cmp("b.in_ready",  {31'b0, bus_b.in_ready}, {31'b0, (mq.size() < 2) && !flush});
    cmp("b.stall_cnt", {30'b0, stall_b}, m_sat);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    set(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset values
    tick();
    cmp("rst out_valid", {31'b0, bus_a.out_valid}, 32'd0);
    cmp("rst out_data", bus_a.out_data, NOP);
    cmp("rst occupancy", {30'b0, occ_a}, 32'd0);
    cmp("rst in_ready", {31'b0, bus_a.in_ready}, 32'd1);
    cmp("rst stall", {16'b0, stall_a}, 32'd0);
    rst = 1'b1;

    // Streaming 1..4 with out_ready high
    for (int k = 1; k <= 4; k++) begin
      set(1'b1, k, 1'b1, 1'b0);
      tick();
      cmp("stream data", bus_a.out_data, k);
      cmp("stream occ", {30'b0, occ_a}, 32'd1);
      cmp("stream stall", {16'b0, stall_a}, 32'd0);
    end
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    cmp("stream drained occ", {30'b0, occ_a}, 32'd0);
    cmp("stream drained data", bus_a.out_data, NOP);

    // Back-pressure: 0xA, 0xB held, then drained in order
    set(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    cmp("bp half data", bus_a.out_data, 32'hA);
    cmp("bp half stall", {16'b0, stall_a}, 32'd0);
    set(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    cmp("bp full occ", {30'b0, occ_a}, 32'd2);
    cmp("bp full in_ready", {31'b0, bus_a.in_ready}, 32'd0);
    cmp("bp full data", bus_a.out_data, 32'hA);
    cmp("bp stall1", {16'b0, stall_a}, 32'd1);
    set(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    cmp("bp stall2", {16'b0, stall_a}, 32'd2);
    tick();
    cmp("bp stall3", {16'b0, stall_a}, 32'd3);
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    cmp("bp drain data", bus_a.out_data, 32'hB);
    cmp("bp drain in_ready", {31'b0, bus_a.in_ready}, 32'd1);
    cmp("bp drain stall", {16'b0, stall_a}, 32'd3);
    tick();
    cmp("bp empty occ", {30'b0, occ_a}, 32'd0);

    // Flush while FULL with out_ready high: 0xA delivered, 0xB discarded
    set(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    set(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    set(1'b1, 32'hC, 1'b1, 1'b1);
    #1;
    cmp("flush in_ready", {31'b0, bus_a.in_ready}, 32'd0);
    tick();
    cmp("flush out_valid", {31'b0, bus_a.out_valid}, 32'd0);
    cmp("flush out_data", bus_a.out_data, NOP);
    cmp("flush occ", {30'b0, occ_a}, 32'd0);
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    cmp("flush no B", {31'b0, bus_a.out_valid}, 32'd0);
    cmp("flush stall kept", {16'b0, stall_a}, 32'd4);

    // rdy low freezes the stage, including a flush offered meanwhile
    set(1'b1, 32'h1, 1'b1, 1'b0);
    tick();
    cmp("rdy half data", bus_a.out_data, 32'h1);
    rdy = 1'b0;
    set(1'b1, 32'h2, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp("rdy frozen data", bus_a.out_data, 32'h1);
      cmp("rdy frozen occ", {30'b0, occ_a}, 32'd1);
      cmp("rdy frozen stall", {16'b0, stall_a}, 32'd4);
    end
    set(1'b1, 32'h2, 1'b1, 1'b1);
    tick();
    cmp("rdy flush ignored", bus_a.out_data, 32'h1);
    rdy = 1'b1;
    set(1'b1, 32'h2, 1'b1, 1'b0);
    tick();
    cmp("rdy resume 2", bus_a.out_data, 32'h2);
    set(1'b1, 32'h3, 1'b1, 1'b0);
    tick();
    cmp("rdy resume 3", bus_a.out_data, 32'h3);
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset pulse between edges while FULL
    set(1'b1, 32'hA, 1'b0, 1'b0);
    tick();
    set(1'b1, 32'hB, 1'b0, 1'b0);
    tick();
    cmp("pre-reset occ", {30'b0, occ_a}, 32'd2);
    cmp("pre-reset stall", {16'b0, stall_a}, 32'd5);
    set(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    cmp("areset out_valid", {31'b0, bus_a.out_valid}, 32'd0);
    cmp("areset occ", {30'b0, occ_a}, 32'd0);
    cmp("areset out_data", bus_a.out_data, NOP);
    cmp("areset stall a", {16'b0, stall_a}, 32'd0);
    cmp("areset stall b", {30'b0, stall_b}, 32'd0);
    #1;
    rst = 1'b1;
    set(1'b1, 32'h5, 1'b1, 1'b0);
    tick();
    cmp("post-reset data", bus_a.out_data, 32'h5);
    cmp("post-reset occ", {30'b0, occ_a}, 32'd1);

    // Saturation of the 2-bit counter over 6 back-pressured cycles
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    set(1'b1, 32'h7, 1'b0, 1'b0);
    tick();
    cmp("sat start", {30'b0, stall_b}, 32'd0);
    set(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp("sat stall b", {30'b0, stall_b}, sat_exp[i]);
      cmp("sat stall a", {16'b0, stall_a}, i + 1);
    end
    set(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    cmp("sat drained occ", {30'b0, occ_b}, 32'd0);
    cmp("sat held b", {30'b0, stall_b}, 32'd3);

    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits (concatenated stage fields).
REQ-002 Parameter NOP_VALUE, default 0 (WIDTH bits): bubble payload presented when the stage is empty.
REQ-003 Parameter CNT_W, default 16: width of the back-pressure statistics counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rdy  input  1  global ready; low freezes all state (no transfers, no counting).
REQ-007 flush  input  1  kill stage contents (branch redirect).
REQ-008 in_valid  input  1  upstream offers payload.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  stage can accept payload.
REQ-011 out_valid  output  1  stage holds valid payload.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 out_ready  input  1  downstream accepts payload.
REQ-014 occupancy  output  2  number of held entries (0..2).
REQ-015 stall_cnt  output  CNT_W  saturating count of back-pressured cycles.

Function
REQ-016 Storage: main register (drives out_data) plus one skid register; states EMPTY, HALF (main valid), FULL (main+skid valid).
REQ-017 fire_in = in_valid & in_ready & rdy; fire_out = out_valid & out_ready & rdy.
REQ-018 in_ready = (state != FULL) & !flush; combinational only from state and flush, never from out_ready.
REQ-019 out_valid = (state != EMPTY), registered; occupancy = 0/1/2 for EMPTY/HALF/FULL.
REQ-020 out_data shall equal NOP_VALUE whenever out_valid is 0.
REQ-021 EMPTY: fire_in -> HALF, main <= in_data; else stay.
REQ-022 HALF: fire_in & fire_out -> HALF, main <= in_data; fire_in only -> FULL, skid <= in_data; fire_out only -> EMPTY, main <= NOP_VALUE; neither -> stay.
REQ-023 FULL: fire_out -> HALF, main <= skid; else stay (fire_in impossible).
REQ-024 Latency: payload accepted in cycle N appears on out_data in cycle N+1 when the stage was EMPTY or draining; throughput one transfer per cycle with out_ready held high.
REQ-025 Ordering: payloads leave in acceptance order; no loss, no duplication.
REQ-026 flush (sampled while rdy high) has top priority: next state EMPTY, main <= NOP_VALUE, skid content discarded, any concurrent fire_out still counts as delivered, in_data that cycle dropped (in_ready already 0).
REQ-027 flush while rdy low shall be ignored; upstream holds flush until rdy returns.
REQ-028 rdy low: state, main, skid, stall_cnt hold; outputs remain stable.
REQ-029 stall_cnt increments by 1 each cycle with rdy & out_valid & !out_ready; saturates at 2^CNT_W-1; never wraps; not cleared by flush.

Reset
REQ-030 rst low asynchronously forces: state EMPTY, main and skid <= NOP_VALUE, stall_cnt <= 0.
REQ-031 During reset: out_valid 0, out_data NOP_VALUE, occupancy 0, in_ready 1 (unless flush high).
REQ-032 Reset asserted mid-transfer discards all held payloads; first edge after release behaves as EMPTY.

Verification
REQ-033 Streaming: in_valid=1, out_ready=1, data 1,2,3,4 -> out_data 1,2,3,4 one cycle later each, occupancy stays 1, stall_cnt 0.
REQ-034 Back-pressure: accept 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready 0, stall_cnt increments per cycle; out_ready=1 -> 0xA then 0xB, in_ready returns 1 after first drain.
REQ-035 Flush in FULL with out_ready=1: out_data 0xA consumed, next cycle out_valid 0, out_data NOP_VALUE, 0xB never appears.
REQ-036 rdy=0 for 3 cycles in HALF with in_valid=1, out_ready=1 -> no transfer, out_data and stall_cnt frozen; rdy=1 resumes with order preserved.
REQ-037 Saturation: CNT_W=2, hold back-pressure 6 cycles -> stall_cnt 1,2,3,3,3,3.
REQ-038 Async reset pulse between edges while FULL -> outputs immediately out_valid 0, occupancy 0, out_data NOP_VALUE, stall_cnt 0.
